// File: rtl/sw_pkg.sv
// Shared constants and types for the board-switch front end.
//
// Contents:
//   SW_WIDTH             number of slide switches on the board
//   SW_DB_CYCLES_DEFAULT debounce window in clk cycles (1 ms at 50 MHz)
//   SW_HS_BIT            switch bit the core samples as its handshake
//   sw_word_t            one full switch word

package sw_pkg;

  localparam int unsigned SW_WIDTH             = 10;
  localparam int unsigned SW_DB_CYCLES_DEFAULT = 50000;
  localparam int unsigned SW_HS_BIT            = 8;

  typedef logic [SW_WIDTH-1:0] sw_word_t;

endpackage

// File: rtl/sw_debounce_bit.sv
// Conditions one switch bit.
//
// The bit is synchronised through two flops. It is then either debounced by a
// stability counter or, in the plain build, registered once more. One-cycle
// rise/fall pulses are produced on the same edge the clean bit changes.
//
// Configuration: macro SW_DEBOUNCE_EN builds the debounce counter; without it
// DB_CYCLES is ignored and the clean bit follows the synchroniser one cycle later.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   raw    raw switch pin, asynchronous to clk
//   clean  conditioned switch bit
//   rise   one-cycle pulse when clean goes 0->1
//   fall   one-cycle pulse when clean goes 1->0

module sw_debounce_bit
  import sw_pkg::*;
#(
  parameter int unsigned DB_CYCLES = SW_DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  // Elaboration-time guard on the legal debounce window.
  if (DB_CYCLES < 2 || DB_CYCLES > 32'd1048576) begin : g_bad_db_cycles
    $error("sw_debounce_bit: DB_CYCLES must be in 2..2^20");
  end

  logic s1_q, s2_q;
  logic clean_q, clean_d;
  logic rise_q, fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DB_CYCLES);

  // Count 0 means idle; non-zero means a change is qualifying.
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    if (s2_q != clean_q) begin
      // Accepting clears the count, so it can never wrap.
      if (cnt_q == CntW'(DB_CYCLES - 1)) begin
        clean_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    clean_d = s2_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      clean_q <= clean_d;
      rise_q  <= clean_d & ~clean_q;
      fall_q  <= ~clean_d & clean_q;
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/sw_input_conditioner.sv
// Board-switch front end for the picoMIPS core.
//
// Turns the raw, asynchronous slide-switch bus into a synchronised, debounced
// switch word for the core's SW input, plus per-bit rise/fall pulses. Every
// output is registered; there is no combinational path from sw_raw.
//
// Configuration: macro SW_DEBOUNCE_EN enables the per-bit debounce counters.
//
// Ports:
//   clk       system clock (same clock as picoMIPS)
//   rst_n     asynchronous active-low reset
//   sw_raw    raw switch pins, asynchronous to clk
//   sw_clean  conditioned switch word, drives the core's SW
//   sw_rise   one-cycle pulse per bit on a 0->1 change of sw_clean
//   sw_fall   one-cycle pulse per bit on a 1->0 change of sw_clean

module sw_input_conditioner
  import sw_pkg::*;
#(
  parameter int unsigned WIDTH     = SW_WIDTH,
  parameter int unsigned DB_CYCLES = SW_DB_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (sw_raw[i]),
      .clean(sw_clean[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i])
    );
  end

endmodule

// File: doc/sw_input_conditioner.md
# sw_input_conditioner

Board-switch front end for the picoMIPS core. It takes the raw, asynchronous slide-switch bus and delivers a synchronised, debounced switch word to the core's `SW` input, plus one-cycle rise/fall pulses per switch. The core uses these to sample the SW[8] handshake without metastability or bounce-induced double reads. It sits between the top-level switch pins and the `picoMIPS` instance, in the same clock domain.

## Interface
- `WIDTH`, 10, number of switch bits conditioned.
- `DB_CYCLES`, 50000, consecutive stable cycles required before a change is accepted (1 ms at 50 MHz); legal range 2..2^20.
- `clk`  input  1  system clock; the same clock that drives `picoMIPS`.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `sw_raw`  input  WIDTH  raw switch pins, asynchronous to `clk`.
- `sw_clean`  output  WIDTH  conditioned switch word; connects to the core's `SW`.
- `sw_rise`  output  WIDTH  one-cycle pulse per bit when `sw_clean[i]` goes 0→1.
- `sw_fall`  output  WIDTH  one-cycle pulse per bit when `sw_clean[i]` goes 1→0.

## Operation
- Each bit is handled independently and identically.
- **Synchroniser:** each bit passes through two flops, `s1` then `s2`. Both reset to 0.
- **Debounce counter:** each bit has a counter of width clog2(DB_CYCLES), reset to 0.
  - Each cycle with `s2 != sw_clean[i]`, the counter increments.
  - When the counter reaches DB_CYCLES-1 and `s2` still differs, the next edge does three things: `sw_clean[i] <= s2`, the counter returns to 0, and the matching pulse is asserted.
- Any cycle with `s2 == sw_clean[i]` clears the counter. A bounce back therefore restarts the count.
- The counter never wraps: it saturates by construction because it clears on acceptance.
- The per-bit state is implicit in the counter: IDLE when the count is 0, QUALIFYING when it is greater than 0.
- `sw_rise[i]` / `sw_fall[i]` are registered and high for exactly one cycle, on the same edge that `sw_clean[i]` changes. Rise and fall are never both high for the same bit.
- Several bits may change on the same edge; each bit's pulse is independent.
- **Reset:** asserting `rst_n` low at any time asynchronously clears `s1`, `s2`, all counters, `sw_clean`, `sw_rise` and `sw_fall` to 0.
  - After release, a switch already at 1 needs the full latency before `sw_clean` shows 1. It then produces an `sw_rise` pulse.

## Timing
- Reset value of every output is 0.
- Count edges from the first `clk` edge at which `sw_raw[i]` holds its new value.
  - `s2` updates at edge 2.
  - With debounce, `sw_clean[i]` and its pulse change at edge 2+DB_CYCLES, provided `sw_raw` stays stable throughout.
- Any glitch shorter than DB_CYCLES cycles (as seen at `s2`) never reaches `sw_clean`.
- There is no combinational path from `sw_raw` to any output.

## Configuration
- Macro `SW_DEBOUNCE_EN`.
- **Defined:** the debounce counters are built and behave as described above.
- **Undefined:** no counters are instantiated and `DB_CYCLES` is ignored.
  - `sw_clean[i]` is a third flop fed from `s2`, so it updates at edge 3.
  - The pulses fire on that same edge.
  - All reset behaviour is unchanged.

## Structure
- Package `sw_pkg` holds:
  - `SW_WIDTH = 10`.
  - `SW_DB_CYCLES_DEFAULT = 50000`.
  - `SW_HS_BIT = 8`, the handshake bit index used by the core.
  - A typedef `sw_word_t` of `logic [SW_WIDTH-1:0]`.
- Sub-module `sw_debounce_bit` handles one bit: synchroniser, counter and edge pulses. The top level generates WIDTH instances.

## Test plan
- **Reset:** run with DB_CYCLES=4. Hold `rst_n`=0 with `sw_raw`=10'h3FF → all outputs 0. Release → `sw_clean`=10'h3FF at edge 6 after release, and `sw_rise`=10'h3FF for one cycle.
- **Clean step:** `sw_raw[8]` 0→1, held → `sw_clean[8]`=1 at edge 6, `sw_rise[8]` high for exactly that cycle, all other bits unchanged.
- **Bounce:** `sw_raw[3]` toggles 1,0,1,0 on alternate cycles, then holds 1 → no change until 6 edges after the final 0→1, then a single `sw_rise[3]` pulse.
- **Simultaneous events:** `sw_raw` changes from 10'h0F0 to 10'h10F in one cycle → at edge 6, `sw_rise`=10'h10F, `sw_fall`=10'h0F0 and `sw_clean`=10'h10F, all together.
- **Reset mid-qualify:** `sw_raw[0]` rises, and `rst_n` is pulsed low at edge 4 → `sw_clean[0]` stays 0. After release, the rise appears exactly 6 edges after the release edge.
- **Macro off:** build without `SW_DEBOUNCE_EN` and step `sw_raw[5]` 0→1 → `sw_clean[5]`=1 at edge 3, with a one-cycle `sw_rise[5]`.
